// File: rtl/ch_fifo_bridge.sv
// ch_fifo_bridge
//   Per-channel bridge between the Wishbone stream engine and a processing
//   module. It contains two independent first-word-fall-through FIFOs:
//     source      : stream engine -> module (ss_*_s_i push, m_src_getn_i pop)
//     destination : module -> stream engine (m_dst_putn_i push, ss_xfer_d_i pop)
//   On top of the buffering it provides:
//     - a 24-bit descriptor-length counter that ends the source stream and
//       tags the final word as last,
//     - almost-full / almost-empty flags with parameterised margins,
//     - occupancy levels and a sticky overflow/underflow error flag.
//
// Ports
//   wb_clk_i, wb_rst_i           clock, asynchronous active-low reset
//   clear_i                      synchronous flush of FIFOs, count, end, error
//   len_load_i, len_i            load source length (0 = unlimited)
//   ss_*_s_*                     source-side engine push and flow control
//   m_src_*                      source FIFO head and status toward the module
//   m_dst_*                      destination FIFO push and status
//   m_endn_i                     module has finished producing (active low)
//   ss_xfer_d_i, ss_dat_d_o      destination FIFO pop / head word
//   ss_*_d_o                     destination-side engine controls
//   src_level_o, dst_level_o     FIFO occupancy
//   err_o                        sticky overflow/underflow flag

// ---------------------------------------------------------------------------
// ch_fifo: one 2^AW x WW FIFO with registered level and FWFT read.
//   Status decodes from the registered level only. push_ok_o and err_o are
//   per-cycle event strobes for the parent (accepted push, overflow or
//   underflow attempt).
// ---------------------------------------------------------------------------
module ch_fifo #(
  parameter int unsigned WW        = 65,
  parameter int unsigned AW        = 9,
  parameter int unsigned AF_MARGIN = 4,
  parameter int unsigned AE_MARGIN = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [WW-1:0] wdat_i,
  output logic [WW-1:0] rdat_o,
  output logic [AW:0]   level_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          afull_o,
  output logic          aempty_o,
  output logic          push_ok_o,
  output logic          err_o
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [WW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          pop_ok;

  assign empty_o  = (level_q == '0);
  assign full_o   = (level_q == (AW+1)'(DEPTH));
  assign afull_o  = (level_q >= (AW+1)'(DEPTH - AF_MARGIN));
  assign aempty_o = (level_q <= (AW+1)'(AE_MARGIN));

  // Acceptance is decided on the registered state: a pop in the same cycle
  // never makes room for a push into a full FIFO.
  assign push_ok_o = push_i & ~full_o;
  assign pop_ok    = pop_i & ~empty_o;
  assign err_o     = (push_i & full_o) | (pop_i & empty_o);

  assign rdat_o  = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok_o) wptr_d = wptr_q + 1'b1;
      if (pop_ok)    rptr_d = rptr_q + 1'b1;
      level_d = level_q + (AW+1)'(push_ok_o) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage carries no reset; head data is meaningless while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok_o && !clr_i) mem_q[wptr_q] <= wdat_i;
  end
endmodule

// ---------------------------------------------------------------------------
// ch_fifo_bridge top
// ---------------------------------------------------------------------------
module ch_fifo_bridge #(
  parameter int unsigned DW        = 64,
  parameter int unsigned AW        = 9,
  parameter int unsigned AF_MARGIN = 4,
  parameter int unsigned AE_MARGIN = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          clear_i,
  input  logic          len_load_i,
  input  logic [23:0]   len_i,
  input  logic          ss_xfer_s_i,
  input  logic [DW-1:0] ss_dat_s_i,
  input  logic          ss_last_s_i,
  output logic          ss_start_s_o,
  output logic          ss_stop_s_o,
  output logic          ss_end_s_o,
  input  logic          m_src_getn_i,
  output logic [DW-1:0] m_src_o,
  output logic          m_src_last_o,
  output logic          m_src_empty_o,
  output logic          m_src_almost_empty_o,
  input  logic          m_dst_putn_i,
  input  logic [DW-1:0] m_dst_i,
  input  logic          m_dst_last_i,
  output logic          m_dst_full_o,
  output logic          m_dst_almost_full_o,
  input  logic          m_endn_i,
  input  logic          ss_xfer_d_i,
  output logic [DW-1:0] ss_dat_d_o,
  output logic          ss_start_d_o,
  output logic          ss_stop_d_o,
  output logic          ss_end_d_o,
  output logic [AW:0]   src_level_o,
  output logic [AW:0]   dst_level_o,
  output logic          err_o
);
  localparam logic [AW:0] HALF = (AW+1)'(1 << (AW-1));

  typedef struct packed {
    logic          last;
    logic [DW-1:0] dat;
  } word_t;

  word_t src_wr, src_rd, dst_wr, dst_rd;
  logic  src_full, src_afull, src_push_ok, src_err;
  logic  dst_empty, dst_aempty, dst_push_ok, dst_err;

  logic [23:0] len_q, len_d, cnt_q, cnt_d;
  logic        end_q, end_d, err_q, err_d;
  logic        len_hit;

  // The word about to be pushed is the len-th one of this descriptor.
  // Once the end has been reached, later pushes never re-tag last.
  assign len_hit = (len_q != '0) && (cnt_q == len_q - 24'd1) && !end_q;

  assign src_wr = '{last: ss_last_s_i | len_hit, dat: ss_dat_s_i};
  assign dst_wr = '{last: m_dst_last_i, dat: m_dst_i};

  ch_fifo #(
    .WW(DW+1), .AW(AW), .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN)
  ) u_src (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_i),
    .clr_i    (clear_i),
    .push_i   (ss_xfer_s_i),
    .pop_i    (~m_src_getn_i),
    .wdat_i   (src_wr),
    .rdat_o   (src_rd),
    .level_o  (src_level_o),
    .empty_o  (m_src_empty_o),
    .full_o   (src_full),
    .afull_o  (src_afull),
    .aempty_o (m_src_almost_empty_o),
    .push_ok_o(src_push_ok),
    .err_o    (src_err)
  );

  ch_fifo #(
    .WW(DW+1), .AW(AW), .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN)
  ) u_dst (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_i),
    .clr_i    (clear_i),
    .push_i   (~m_dst_putn_i),
    .pop_i    (ss_xfer_d_i),
    .wdat_i   (dst_wr),
    .rdat_o   (dst_rd),
    .level_o  (dst_level_o),
    .empty_o  (dst_empty),
    .full_o   (m_dst_full_o),
    .afull_o  (m_dst_almost_full_o),
    .aempty_o (dst_aempty),
    .push_ok_o(dst_push_ok),
    .err_o    (dst_err)
  );

  logic unused_sig;
  assign unused_sig = ^{src_full, dst_aempty, dst_push_ok};

  // Length counter: clear beats load, load beats a concurrent push.
  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    end_d = end_q;
    if (clear_i) begin
      cnt_d = '0;
      end_d = 1'b0;
    end else if (len_load_i) begin
      len_d = len_i;
      cnt_d = '0;
      end_d = 1'b0;
    end else if (src_push_ok) begin
      cnt_d = cnt_q + 24'd1;
      if (len_hit) end_d = 1'b1;
    end
  end

  assign err_d = clear_i ? 1'b0 : (err_q | src_err | dst_err);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      len_q <= '0;
      cnt_q <= '0;
      end_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
      end_q <= end_d;
      err_q <= err_d;
    end
  end

  // Head data is raw array output; the last tags are qualified by non-empty
  // so they read 0 out of reset regardless of array contents.
  assign m_src_o      = src_rd.dat;
  assign m_src_last_o = src_rd.last & ~m_src_empty_o;
  assign ss_dat_d_o   = dst_rd.dat;
  assign ss_end_d_o   = dst_rd.last & ~dst_empty;

  assign ss_end_s_o   = end_q;
  assign ss_start_s_o = (src_level_o < HALF) & ~end_q;
  assign ss_stop_s_o  = src_afull | end_q;

  assign ss_start_d_o = (dst_level_o >= HALF) | (~m_endn_i & ~dst_empty);
  assign ss_stop_d_o  = m_dst_almost_full_o;

  assign err_o = err_q;
endmodule

// File: doc/ch_fifo_bridge.md
# ch_fifo_bridge

Parametrised per-channel data bridge between the Wishbone stream engine and a processing module. It holds two independent FIFOs: a source FIFO (stream engine -> module) and a destination FIFO (module -> stream engine). On top of the buffering it adds three things:
- a descriptor-length counter that terminates the source stream on its own and tags the final word as last;
- programmable almost-full and almost-empty margins;
- occupancy level outputs and a sticky overflow/underflow error flag.

## Interface
Parameters:
- DW, 64, data word width (multiple of 32)
- AW, 9, FIFO address width; each FIFO depth is 2^AW
- AF_MARGIN, 4, almost_full asserts when level >= 2^AW - AF_MARGIN
- AE_MARGIN, 4, almost_empty asserts when level <= AE_MARGIN

Ports:
- wb_clk_i  in  1  sole clock, rising edge
- wb_rst_i  in  1  reset; asynchronous assert, active-low
- clear_i  in  1  synchronous flush of both FIFOs, length counter and err_o
- len_load_i  in  1  one-cycle pulse; loads len_i and restarts the source word count
- len_i  in  24  source transfer length in DW words; 0 = unlimited
- ss_xfer_s_i  in  1  push ss_dat_s_i / ss_last_s_i into the source FIFO
- ss_dat_s_i  in  DW  source write data
- ss_last_s_i  in  1  explicit last tag for the pushed word
- ss_start_s_o  out  1  engine may begin a read burst
- ss_stop_s_o  out  1  engine must stop pushing
- ss_end_s_o  out  1  source length reached
- m_src_getn_i  in  1  active-low pop of the source FIFO head
- m_src_o  out  DW  source FIFO head word (first-word fall-through)
- m_src_last_o  out  1  last tag of the head word
- m_src_empty_o / m_src_almost_empty_o  out  1 each  source FIFO status
- m_dst_putn_i  in  1  active-low push into the destination FIFO
- m_dst_i  in  DW  destination write data
- m_dst_last_i  in  1  last tag for the pushed destination word
- m_dst_full_o / m_dst_almost_full_o  out  1 each  destination FIFO status
- m_endn_i  in  1  active-low: module has finished producing data
- ss_xfer_d_i  in  1  pop the destination FIFO head
- ss_dat_d_o  out  DW  destination FIFO head word (first-word fall-through)
- ss_start_d_o / ss_stop_d_o / ss_end_d_o  out  1 each  destination-side engine controls
- src_level_o / dst_level_o  out  AW+1  current FIFO occupancy
- err_o  out  1  sticky error: overflow or underflow on either FIFO

## Operation
- Each FIFO is a 2^AW x (DW+1) array. It has a write pointer and a read pointer, each AW bits and wrapping modulo 2^AW, and an AW+1-bit level register.
- Empty means level == 0. Full means level == 2^AW. Almost-full and almost-empty thresholds come from the parameters.
- Push while full: the word is dropped, the pointer does not move, err_o is set. This applies even if a pop happens in the same cycle.
- Pop while empty: ignored, err_o is set. A push in the same cycle is still accepted.
- Push and pop in the same cycle, FIFO neither full nor empty: both pointers advance and the level is unchanged.
- Source length counter (24 bits):
  - len_load_i clears the count and latches len_i.
  - Each accepted source push increments the count.
  - Stored last bit = ss_last_s_i OR (len != 0 AND count == len-1).
  - ss_end_s_o is set when count reaches len (len != 0). It is cleared by len_load_i or clear_i.
  - Pushes after ss_end_s_o are accepted and counted, but never re-tag last.
- ss_start_s_o = (src_level < 2^(AW-1)) AND NOT ss_end_s_o.
- ss_stop_s_o = src almost_full OR ss_end_s_o.
- ss_start_d_o = (dst_level >= 2^(AW-1)) OR (NOT m_endn_i AND dst level != 0).
- ss_stop_d_o = m_dst_almost_full_o.
- ss_end_d_o = head last bit AND destination FIFO not empty.
- clear_i: both levels and pointers return to 0, the count returns to 0, ss_end_s_o and err_o clear. It wins over any push or pop in the same cycle.

## Timing
- Reset values: all levels 0, so m_src_empty_o = 1 and m_src_almost_empty_o = 1. The following are 0:
  - m_dst_full_o, m_dst_almost_full_o
  - ss_stop_s_o, ss_end_s_o, ss_start_d_o, ss_stop_d_o, ss_end_d_o
  - err_o, m_src_last_o
- ss_start_s_o resets to 1.
- m_src_o and ss_dat_d_o are don't-care while the FIFO is empty. Drive them from the array with no reset.
- Push-to-visible latency is 1 cycle: a word pushed at edge N is on the head output and counted in the level after edge N. m_src_empty_o falls in that same cycle.
- Read is first-word fall-through: a pop at edge N presents the next word after edge N, with zero-cycle read latency.
- All status outputs decode combinationally from the registered level, pointers and count. They never depend combinationally on push or pop inputs.
- Asynchronous reset takes effect mid-transfer, discarding contents. The first push is accepted on the first clock edge after deassertion.

## Test plan
- Reset, then idle: m_src_empty_o = 1, ss_start_s_o = 1, every other output 0, both levels 0.
- len_i = 3 loaded, then 5 source pushes with ss_last_s_i = 0:
  - ss_end_s_o rises after the 3rd push and ss_stop_s_o = 1.
  - Popping returns words 1..5 in order, with m_src_last_o = 1 only on word 3.
- AW = 4: 16 destination pushes.
  - m_dst_almost_full_o = 1 at level 12, m_dst_full_o = 1 at level 16, ss_start_d_o = 1 from level 8.
  - A 17th push is dropped and err_o = 1.
  - Popping returns 16 words, wrapping the pointers correctly.
- Simultaneous push and pop at level 5: level stays 5, data order is preserved. Same at level 0: push accepted, level becomes 1, err_o = 1.
- 2 destination words with the second tagged last, m_endn_i = 0: ss_start_d_o = 1 below half-full; ss_end_d_o = 1 only while the tagged word is at the head.
- clear_i during a concurrent push at level 7: level becomes 0 and err_o becomes 0. Asserting wb_rst_i low mid-stream gives the same all-reset values.
